// File: rtl/btn_pulse_gen_pkg.sv
// Shared definitions for the push-button conditioning stage: FSM state encodings and
// default parameter values used by btn_pulse_gen and its synchroniser.
package btn_pulse_gen_pkg;

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] HELD         = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 8;
    localparam int DEF_REPEAT_DELAY  = 16;
    localparam int DEF_REPEAT_PERIOD = 8;

endpackage

// File: rtl/btn_pulse_gen_if.sv
// Button-side signal bundle: raw button level in, debounced level and press strobe out.
interface btn_pulse_gen_if;

    logic btn_in;
    logic pulse;
    logic level;

    modport master (output btn_in, input pulse, input level);
    modport slave  (input btn_in, output pulse, output level);

endinterface

// File: rtl/bit_sync.sv
// Single-bit flop-chain synchroniser with synchronous active-high reset; out is the last flop.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/btn_pulse_gen.sv
// Synchronises and debounces a raw push button, emitting one pulse per accepted press.
// Define BTN_PULSE_REPEAT_EN to add auto-repeat pulses while the button stays held.
module btn_pulse_gen
    import btn_pulse_gen_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
`ifdef BTN_PULSE_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
    input  logic             clk,
    input  logic             reset,
    btn_pulse_gen_if.slave   bus,
    output logic [1:0]       state_dbg
);

    logic             s;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.btn_in),
        .q     (s)
    );

`ifdef BTN_PULSE_REPEAT_EN
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [CNT_W-1:0] rep_nxt;
    assign rep_nxt = rep_cnt_q + CNT_W'(1);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
`ifdef BTN_PULSE_REPEAT_EN
        rep_cnt_d = '0;
`endif
        case (state_q)
            IDLE: begin
                level_d = 1'b0;
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d = HELD;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                level_d = 1'b1;
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
`ifdef BTN_PULSE_REPEAT_EN
                // After the first repeat the counter is rewound one period so every later
                // repeat lands on the same compare value (assumes REPEAT_DELAY >= REPEAT_PERIOD).
                else if (rep_nxt == CNT_W'(REPEAT_DELAY)) begin
                    pulse_d   = 1'b1;
                    rep_cnt_d = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
                end else begin
                    rep_cnt_d = rep_nxt;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef BTN_PULSE_REPEAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`endif

    assign bus.pulse = pulse_q;
    assign bus.level = level_q;
    assign state_dbg = state_q;

endmodule

// File: doc/btn_pulse_gen.md
Name: btn_pulse_gen

Overview:
Upstream conditioning stage for the toggle flip-flop. It synchronises a raw, bouncy push-button input and debounces it. Each accepted press produces exactly one single-cycle pulse. That pulse drives the toggle stage's `in` directly, so one physical press flips the toggled output exactly once.

Parameters:
- SYNC_STAGES, 2, flip-flops in the input synchroniser chain (>=2).
- STABLE_CYCLES, 4, consecutive equal synchronised samples required to accept a level change (>=2).
- CNT_W, 8, width of the debounce and repeat counters. Must hold max(STABLE_CYCLES, REPEAT_DELAY).
- REPEAT_DELAY, 16, hold cycles before the first auto-repeat pulse. Used only with the optional feature.
- REPEAT_PERIOD, 8, cycles between later auto-repeat pulses (>=2). Used only with the optional feature.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- btn_in  input  1  raw button level; asynchronous to clk, may bounce
- pulse  output  1  one-cycle press strobe; registered; feeds the toggle stage input
- level  output  1  debounced button level; registered

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. At a reset edge the following all clear to 0:
  - synchroniser flops
  - debounce counter cnt and repeat counter rep_cnt
  - state, which goes to IDLE
  - pulse and level
- reset has priority over every other event, including a reset arriving mid-debounce.
- Synchroniser: s is the last synchroniser flop. s follows btn_in with SYNC_STAGES-1 edges of delay after the first capture.
- FSM (4 states):
  - IDLE: level=0. If s=1, go to PRESS_WAIT and set cnt=1.
  - PRESS_WAIT:
    - If s=0, go to IDLE and set cnt=0 (bounce rejected, no pulse).
    - Else if cnt==STABLE_CYCLES-1, go to HELD, set level=1, pulse=1, cnt=0.
    - Else increment cnt.
  - HELD: level=1. If s=0, go to RELEASE_WAIT and set cnt=1.
  - RELEASE_WAIT:
    - If s=1, return to HELD and set cnt=0 (no pulse).
    - Else if cnt==STABLE_CYCLES-1, go to IDLE, set level=0, cnt=0.
    - Else increment cnt.
- Latency: btn_in goes high (set up before edge 0) and stays stable. pulse is high only in the cycle after edge SYNC_STAGES+STABLE_CYCLES-1, which is edge 5 with defaults. level rises at the same edge.
- Release produces no pulse. level falls SYNC_STAGES+STABLE_CYCLES-1 edges after a clean release.
- pulse is 0 in every cycle not listed above. Two pulses are never adjacent.
- Counters saturate-free: cnt never exceeds STABLE_CYCLES-1, so it never wraps.

Optional Feature:
- Macro: BTN_PULSE_REPEAT_EN.
- Defined: while in HELD, rep_cnt counts cycles, starting at 0 on the edge that enters HELD.
  - Extra pulses fire REPEAT_DELAY cycles after HELD entry, then every REPEAT_PERIOD cycles while HELD persists.
  - rep_cnt clears whenever the state is not HELD, so a release bounce restarts the delay.
- Undefined: no rep_cnt logic is present. Exactly one pulse per press.

Decomposition:
- Shared header btn_pulse_defs.vh holds:
  - state encodings: IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3
  - default parameter values
- One sub-module, bit_sync: a parameterised SYNC_STAGES flop chain with synchronous, active-high reset. It is instantiated once.

Test Plan (default parameters):
- Reset: hold reset 3 cycles with btn_in=1 -> pulse=0, level=0 throughout. After reset falls, the first pulse appears 5 edges later.
- Clean press: btn_in 0->1 before edge 0, held for 30 cycles -> pulse=1 only after edge 5; level=1 from edge 5 onward.
- Press bounce: btn_in high 2 cycles, low 1 cycle, then high steady -> no pulse during the bounce. Exactly one pulse, 5 edges after the final rise.
- Short glitch: btn_in high 3 cycles, then low -> no pulse; level stays 0.
- Release bounce: while HELD, btn_in low 2 cycles then high -> level stays 1, no pulse. A full release then gives level=0 five edges later, still no pulse.
- Mid-operation reset: assert reset while in PRESS_WAIT with cnt=2, keeping btn_in=1 -> state returns to IDLE. Pulse appears 5 edges after reset deasserts.
- Repeat (BTN_PULSE_REPEAT_EN defined): hold 45 cycles past HELD entry edge E -> pulses after edges E, E+16, E+24, E+32, E+40, and none at any other edge.
